// File: rtl/padframe_cfg_seq_pkg.sv
// rtl/padframe_cfg_seq_pkg.sv - shared types and helpers for the padframe config sequencer
package padframe_cfg_seq_pkg;

    localparam int CFG_AW = 32;
    localparam int CFG_DW = 32;
    localparam int CFG_SW = CFG_DW / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_CHK,
        ST_NEXT,
        ST_DONE,
        ST_ERR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_BUS      = 2'd1,
        ERR_MISMATCH = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_code_e;

    typedef struct packed {
        logic [CFG_AW-1:0] addr;
        logic [CFG_DW-1:0] data;
        logic [CFG_SW-1:0] strb;
    } entry_t;

    // Expand byte strobes into a per-bit compare mask.
    function automatic logic [CFG_DW-1:0] strb_to_mask(input logic [CFG_SW-1:0] strb);
        logic [CFG_DW-1:0] mask;
        for (int i = 0; i < CFG_SW; i++) begin
            mask[i*8 +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/padframe_cfg_seq_table.sv
// rtl/padframe_cfg_seq_table.sv - entry register file, one write port and one async read port
module padframe_cfg_seq_table
    import padframe_cfg_seq_pkg::*;
#(
    parameter int NumEntries = 16,
    localparam int IdxWidth = $clog2(NumEntries)
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [IdxWidth-1:0] wr_idx,
    input  entry_t              wr_entry,
    input  logic [IdxWidth-1:0] rd_idx,
    output entry_t              rd_entry
);

    // Contents survive reset so a restart replays the preloaded table.
    entry_t mem_q [NumEntries];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_entry;
        end
    end

    assign rd_entry = mem_q[rd_idx];

endmodule

// File: rtl/padframe_cfg_seq.sv
// rtl/padframe_cfg_seq.sv - boot-time padframe register write sequencer with optional read-back verify
module padframe_cfg_seq
    import padframe_cfg_seq_pkg::*;
#(
    parameter int NumEntries    = 16,
    parameter int AddrWidth     = CFG_AW,
    parameter int DataWidth     = CFG_DW,
    parameter int TimeoutCycles = 255,
    localparam int StrbWidth    = DataWidth / 8,
    localparam int IdxWidth     = $clog2(NumEntries),
    localparam int NumWidth     = IdxWidth + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_valid_i,
    output logic                 load_ready_o,
    input  logic [IdxWidth-1:0]  load_idx_i,
    input  logic [AddrWidth-1:0] load_addr_i,
    input  logic [DataWidth-1:0] load_data_i,
    input  logic [StrbWidth-1:0] load_strb_i,
    input  logic                 start_i,
    input  logic [NumWidth-1:0]  num_i,
    input  logic                 verify_en_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [IdxWidth-1:0]  err_idx_o,
    output logic [1:0]           err_code_o,
    output logic [AddrWidth-1:0] cfg_addr_o,
    output logic                 cfg_write_o,
    output logic [DataWidth-1:0] cfg_wdata_o,
    output logic [StrbWidth-1:0] cfg_wstrb_o,
    output logic                 cfg_valid_o,
    input  logic [DataWidth-1:0] cfg_rdata_i,
    input  logic                 cfg_error_i,
    input  logic                 cfg_ready_i
);

    localparam int TcntWidth = $clog2(TimeoutCycles + 1);
    localparam logic [NumWidth-1:0]  NUM_MAX   = NumWidth'(NumEntries);
    localparam logic [TcntWidth-1:0] TCNT_LAST = TcntWidth'(TimeoutCycles - 1);

    state_e                 state_q;
    logic [IdxWidth-1:0]    idx_q;
    logic [NumWidth-1:0]    num_q;
    logic                   verify_q;
    logic [TcntWidth-1:0]   tcnt_q;
    logic [StrbWidth-1:0]   strb_q;
    logic [DataWidth-1:0]   rdata_q;

    logic                   load_fire;
    logic                   start_fire;
    logic                   last;
    logic                   launch;
    logic [NumWidth-1:0]    num_eff;
    logic [IdxWidth-1:0]    rd_idx;
    entry_t                 load_entry;
    entry_t                 rd_entry;
    entry_t                 issue_entry;

    assign busy_o       = state_q inside {ST_WR, ST_RD, ST_CHK, ST_NEXT};
    assign load_ready_o = !busy_o;
    assign load_fire    = load_valid_i && !busy_o;
    assign start_fire   = start_i && !busy_o;
    assign num_eff      = (num_i > NUM_MAX) ? NUM_MAX : num_i;
    assign last         = ({1'b0, idx_q} == num_q - 1'b1);
    assign launch       = (start_fire && num_eff != '0) || (state_q == ST_NEXT && !last);
    assign load_entry   = {load_addr_i, load_data_i, load_strb_i};

    // Request fields are loaded one cycle ahead: entry 0 on start, idx+1 from NEXT.
    assign rd_idx       = busy_o ? idx_q + 1'b1 : '0;
    // A load landing in the start cycle must be visible to the first request.
    assign issue_entry  = (load_fire && load_idx_i == rd_idx) ? load_entry : rd_entry;

    padframe_cfg_seq_table #(
        .NumEntries (NumEntries)
    ) u_table (
        .clk      (clk_i),
        .wr_en    (load_fire),
        .wr_idx   (load_idx_i),
        .wr_entry (load_entry),
        .rd_idx   (rd_idx),
        .rd_entry (rd_entry)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            num_q       <= '0;
            verify_q    <= 1'b0;
            tcnt_q      <= '0;
            strb_q      <= '0;
            rdata_q     <= '0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            err_idx_o   <= '0;
            err_code_o  <= ERR_NONE;
            cfg_addr_o  <= '0;
            cfg_write_o <= 1'b0;
            cfg_wdata_o <= '0;
            cfg_wstrb_o <= '0;
            cfg_valid_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_fire) begin
                        num_q      <= num_eff;
                        verify_q   <= verify_en_i;
                        idx_q      <= '0;
                        err_o      <= 1'b0;
                        err_idx_o  <= '0;
                        err_code_o <= ERR_NONE;
                        if (num_eff == '0) begin
                            state_q <= ST_DONE;
                            done_o  <= 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    if (cfg_ready_i) begin
                        cfg_valid_o <= 1'b0;
                        tcnt_q      <= '0;
                        if (cfg_error_i) begin
                            state_q    <= ST_ERR;
                            err_o      <= 1'b1;
                            err_idx_o  <= idx_q;
                            err_code_o <= ERR_BUS;
                        end else if (verify_q) begin
                            state_q     <= ST_RD;
                            cfg_write_o <= 1'b0;
                            cfg_wstrb_o <= '0;
                        end else begin
                            state_q <= ST_NEXT;
                        end
                    end else if (tcnt_q == TCNT_LAST) begin
                        cfg_valid_o <= 1'b0;
                        state_q     <= ST_ERR;
                        err_o       <= 1'b1;
                        err_idx_o   <= idx_q;
                        err_code_o  <= ERR_TIMEOUT;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                ST_RD: begin
                    // First RD cycle is the mandatory idle gap after the write.
                    if (!cfg_valid_o) begin
                        cfg_valid_o <= 1'b1;
                    end else if (cfg_ready_i) begin
                        cfg_valid_o <= 1'b0;
                        if (cfg_error_i) begin
                            state_q    <= ST_ERR;
                            err_o      <= 1'b1;
                            err_idx_o  <= idx_q;
                            err_code_o <= ERR_BUS;
                        end else begin
                            rdata_q <= cfg_rdata_i;
                            state_q <= ST_CHK;
                        end
                    end else if (tcnt_q == TCNT_LAST) begin
                        cfg_valid_o <= 1'b0;
                        state_q     <= ST_ERR;
                        err_o       <= 1'b1;
                        err_idx_o   <= idx_q;
                        err_code_o  <= ERR_TIMEOUT;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                ST_CHK: begin
                    if (((rdata_q ^ cfg_wdata_o) & strb_to_mask(strb_q)) != '0) begin
                        state_q    <= ST_ERR;
                        err_o      <= 1'b1;
                        err_idx_o  <= idx_q;
                        err_code_o <= ERR_MISMATCH;
                    end else begin
                        state_q <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (last) begin
                        state_q <= ST_DONE;
                        done_o  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (launch) begin
                state_q     <= ST_WR;
                cfg_valid_o <= 1'b1;
                cfg_write_o <= 1'b1;
                cfg_addr_o  <= issue_entry.addr;
                cfg_wdata_o <= issue_entry.data;
                cfg_wstrb_o <= issue_entry.strb;
                strb_q      <= issue_entry.strb;
                tcnt_q      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_padframe_cfg_seq.sv
// tb/tb_padframe_cfg_seq.sv - scoreboard bench with randomized slave and reference model
module tb_padframe_cfg_seq;

    localparam int NE = 16;
    localparam int TO = 4;

    typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } req_t;
    typedef struct { int delay; bit err; logic [31:0] rdata; } plan_t;
    typedef struct { bit is_err; int idx; int code; } end_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [3:0]  load_idx = '0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic [3:0]  load_strb = '0;
    logic        start = 1'b0;
    logic [4:0]  num = '0;
    logic        verify_en = 1'b0;
    logic        load_ready, busy, done, err;
    logic [3:0]  err_idx;
    logic [1:0]  err_code;
    logic [31:0] cfg_addr, cfg_wdata;
    logic        cfg_write, cfg_valid;
    logic [3:0]  cfg_wstrb;
    logic [31:0] cfg_rdata = '0;
    logic        cfg_error = 1'b0;
    logic        cfg_ready = 1'b0;

    logic [31:0] m_addr [NE];
    logic [31:0] m_data [NE];
    logic [3:0]  m_strb [NE];
    req_t  exp_req_q [$];
    plan_t slave_q [$];
    end_t  exp_end_q [$];
    int vecs = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    padframe_cfg_seq #(
        .NumEntries (NE),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .load_valid_i (load_valid),
        .load_ready_o (load_ready),
        .load_idx_i   (load_idx),
        .load_addr_i  (load_addr),
        .load_data_i  (load_data),
        .load_strb_i  (load_strb),
        .start_i      (start),
        .num_i        (num),
        .verify_en_i  (verify_en),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .err_idx_o    (err_idx),
        .err_code_o   (err_code),
        .cfg_addr_o   (cfg_addr),
        .cfg_write_o  (cfg_write),
        .cfg_wdata_o  (cfg_wdata),
        .cfg_wstrb_o  (cfg_wstrb),
        .cfg_valid_o  (cfg_valid),
        .cfg_rdata_i  (cfg_rdata),
        .cfg_error_i  (cfg_error),
        .cfg_ready_i  (cfg_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] s);
        logic [31:0] m = 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
        return m;
    endfunction

    // Reference: walk entries in order, each write optionally followed by a read-back; stop at first failure.
    task automatic model_seq(input int n_req, input bit ver, input bit rnd, input int fix_delay,
                             input int err_req, input int bad_idx, input logic [31:0] bad_rdata);
        int n, k;
        plan_t p;
        req_t r;
        end_t e;
        logic [31:0] mask;
        n = (n_req > NE) ? NE : n_req;
        k = 0;
        e.is_err = 1'b0; e.idx = 0; e.code = 0;
        for (int i = 0; i < n && !e.is_err; i++) begin
            mask = byte_mask(m_strb[i]);
            for (int ph = 0; ph < (ver ? 2 : 1) && !e.is_err; ph++) begin
                r.wr = (ph == 0); r.addr = m_addr[i]; r.data = m_data[i];
                r.strb = (ph == 0) ? m_strb[i] : 4'h0;
                exp_req_q.push_back(r);
                if (rnd) begin
                    p.delay = ($urandom_range(0, 39) < 38) ? int'($urandom_range(0, 3)) : int'($urandom_range(TO, TO + 2));
                    p.err = ($urandom_range(0, 29) == 0);
                    case ($urandom_range(0, 9))
                        7:       p.rdata = m_data[i] ^ (~mask & $urandom());
                        8, 9:    p.rdata = $urandom();
                        default: p.rdata = m_data[i];
                    endcase
                end else begin
                    p.delay = fix_delay;
                    p.err = (k == err_req);
                    p.rdata = (i == bad_idx) ? bad_rdata : m_data[i];
                end
                slave_q.push_back(p);
                if (p.delay >= TO) begin
                    e.is_err = 1'b1; e.idx = i; e.code = 3;
                end else if (p.err) begin
                    e.is_err = 1'b1; e.idx = i; e.code = 1;
                end else if (ph == 1 && ((p.rdata ^ m_data[i]) & mask) != 32'h0) begin
                    e.is_err = 1'b1; e.idx = i; e.code = 2;
                end
                k++;
            end
        end
        exp_end_q.push_back(e);
    endtask

    task automatic load_entry(input int idx, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input bit applied);
        load_valid = 1'b1; load_idx = 4'(idx); load_addr = a; load_data = d; load_strb = s;
        tick();
        load_valid = 1'b0;
        if (applied) begin
            m_addr[idx] = a; m_data[idx] = d; m_strb[idx] = s;
        end
    endtask

    task automatic start_seq(input int n, input bit ver);
        start = 1'b1; num = 5'(n); verify_en = ver;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int c = 0;
        while (exp_end_q.size() != 0 && c < 3000) begin
            tick();
            c++;
        end
        vecs++;
        if (exp_end_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_outcome: no outcome after %0d cycles, expected done or err", name, c);
            exp_end_q.delete();
        end
        repeat (2) tick();
        check({name, "_reqs_left"}, exp_req_q.size(), 0);
        exp_req_q.delete();
        slave_q.delete();
    endtask

    initial begin : slave
        plan_t p;
        bit have;
        int wait_cnt;
        have = 1'b0;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            cfg_ready = 1'b0; cfg_error = 1'b0; cfg_rdata = '0;
            if (rst || !cfg_valid) begin
                have = 1'b0;
            end else begin
                if (!have && slave_q.size() != 0) begin
                    p = slave_q.pop_front();
                    have = 1'b1;
                    wait_cnt = p.delay;
                end
                if (have) begin
                    if (wait_cnt == 0) begin
                        cfg_ready = 1'b1; cfg_error = p.err; cfg_rdata = p.rdata;
                        have = 1'b0;
                    end else begin
                        wait_cnt--;
                    end
                end
            end
        end
    end

    initial begin : monitor
        req_t r;
        end_t e;
        bit prev_valid, prev_err;
        prev_valid = 1'b0;
        prev_err = 1'b0;
        r.wr = 1'b0; r.addr = '0; r.data = '0; r.strb = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                prev_err = 1'b0;
            end else begin
                if (cfg_valid && !prev_valid) begin
                    if (exp_req_q.size() == 0) begin
                        vecs++; miscompares++;
                        $display("FAIL unexpected_req: got addr 0x%0h write %0d, expected no request", cfg_addr, cfg_write);
                    end else begin
                        r = exp_req_q.pop_front();
                        check("req_write", cfg_write, r.wr);
                        check("req_addr", cfg_addr, r.addr);
                        check("req_wstrb", cfg_wstrb, r.strb);
                        if (r.wr) check("req_wdata", cfg_wdata, r.data);
                    end
                end else if (cfg_valid) begin
                    check("req_addr_hold", cfg_addr, r.addr);
                end
                prev_valid = cfg_valid;
                if (done) begin
                    if (exp_end_q.size() == 0) begin
                        vecs++; miscompares++;
                        $display("FAIL unexpected_done: got done pulse, expected none");
                    end else begin
                        e = exp_end_q.pop_front();
                        check("end_is_err", 0, e.is_err);
                        check("done_err_low", err, 0);
                    end
                end
                if (err && !prev_err) begin
                    if (exp_end_q.size() == 0) begin
                        vecs++; miscompares++;
                        $display("FAIL unexpected_err: got idx %0d code %0d, expected none", err_idx, err_code);
                    end else begin
                        e = exp_end_q.pop_front();
                        check("end_is_err", 1, e.is_err);
                        check("err_idx", err_idx, e.idx);
                        check("err_code", err_code, e.code);
                    end
                end
                prev_err = err;
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin : driver
        int cnt;
        repeat (3) tick();
        check("rst_load_ready", load_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_cfg_valid", cfg_valid, 0);
        check("rst_cfg_addr", cfg_addr, 0);
        rst = 1'b0;
        tick();

        load_entry(0, 32'h00, 32'h1, 4'hF, 1'b1);
        load_entry(1, 32'h04, 32'h3, 4'hF, 1'b1);
        load_entry(2, 32'h08, 32'hA5, 4'hF, 1'b1);

        model_seq(3, 1'b0, 1'b0, 1, -1, -1, 32'h0);
        start_seq(3, 1'b0);
        wait_end("basic_write");

        model_seq(3, 1'b1, 1'b0, 1, -1, -1, 32'h0);
        start_seq(3, 1'b1);
        wait_end("verify_pass");

        model_seq(3, 1'b1, 1'b0, 1, -1, 2, 32'hA4);
        start_seq(3, 1'b1);
        wait_end("verify_mismatch");

        load_entry(1, 32'h04, 32'hFF, 4'h1, 1'b1);
        model_seq(3, 1'b1, 1'b0, 0, -1, 1, 32'hDEAD_BEFF);
        start_seq(3, 1'b1);
        wait_end("partial_strb");

        model_seq(3, 1'b0, 1'b0, 1, 0, -1, 32'h0);
        start_seq(3, 1'b0);
        wait_end("bus_error");

        model_seq(3, 1'b0, 1'b0, 100, -1, -1, 32'h0);
        start_seq(3, 1'b0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (cfg_valid) cnt++;
            else if (cnt > 0) break;
            tick();
        end
        check("timeout_valid_cycles", cnt, TO);
        wait_end("timeout");

        model_seq(0, 1'b0, 1'b0, 1, -1, -1, 32'h0);
        start_seq(0, 1'b0);
        check("num0_done", done, 1);
        tick();
        check("num0_done_pulse", done, 0);
        check("num0_busy", busy, 0);
        wait_end("num0");

        model_seq(3, 1'b0, 1'b0, 2, -1, -1, 32'h0);
        start_seq(3, 1'b0);
        tick();
        start_seq(5, 1'b1);
        load_entry(2, 32'hBAD0, 32'hBAD1, 4'h3, 1'b0);
        wait_end("busy_ignore");
        model_seq(3, 1'b0, 1'b0, 0, -1, -1, 32'h0);
        start_seq(3, 1'b0);
        wait_end("table_kept");

        m_addr[0] = 32'h10; m_data[0] = 32'h5A5A_0F0F; m_strb[0] = 4'hF;
        model_seq(2, 1'b1, 1'b0, 0, -1, -1, 32'h0);
        load_valid = 1'b1; load_idx = 4'h0; load_addr = 32'h10; load_data = 32'h5A5A_0F0F; load_strb = 4'hF;
        start = 1'b1; num = 5'd2; verify_en = 1'b1;
        tick();
        load_valid = 1'b0; start = 1'b0;
        wait_end("load_start");

        for (int i = 0; i < NE; i++) load_entry(i, $urandom(), $urandom(), 4'($urandom_range(0, 15)), 1'b1);
        model_seq(20, 1'b0, 1'b0, 0, -1, -1, 32'h0);
        start_seq(20, 1'b0);
        wait_end("num_clamp");

        model_seq(3, 1'b0, 1'b0, 100, -1, -1, 32'h0);
        start_seq(3, 1'b0);
        tick();
        check("midrst_valid_before", cfg_valid, 1);
        rst = 1'b1;
        tick();
        check("midrst_valid", cfg_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_load_ready", load_ready, 1);
        exp_req_q.delete(); slave_q.delete(); exp_end_q.delete();
        rst = 1'b0;
        tick();
        model_seq(3, 1'b1, 1'b0, 1, -1, -1, 32'h0);
        start_seq(3, 1'b1);
        wait_end("restart");

        for (int it = 0; it < 30; it++) begin
            int nl, n;
            bit ver;
            nl = $urandom_range(0, 3);
            for (int j = 0; j < nl; j++)
                load_entry($urandom_range(0, NE - 1), $urandom(), $urandom(), 4'($urandom_range(0, 15)), 1'b1);
            n = $urandom_range(0, 18);
            ver = 1'($urandom_range(0, 1));
            model_seq(n, ver, 1'b1, 0, -1, -1, 32'h0);
            start_seq(n, ver);
            wait_end("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
